// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, IF/ID register and run/halt control.
// Program end is a zero instruction word; misaligned redirects halt fetch.
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [63:0] redirect_target,
    input  logic [31:0] inst_in,
    output logic [63:0] pc_out,
    output logic [63:0] if_id_pc,
    output logic [31:0] if_id_inst,
    output logic        if_id_valid,
    output logic        halted,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    localparam logic [1:0] START = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] HALT  = 2'd2;

    logic [1:0] state;
    logic       aligned;

    assign aligned = (redirect_target[1:0] == 2'b00);
    assign halted  = (state == HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= START;
            pc_out       <= RESET_PC;
            if_id_pc     <= 64'h0;
            if_id_inst   <= 32'h0;
            if_id_valid  <= 1'b0;
            misalign_err <= 1'b0;
            fetch_count  <= 32'h0;
        end else begin
            case (state)
                START: begin
                    if_id_valid <= 1'b0;
                    state       <= RUN;
                end
                RUN: begin
                    // redirect outranks stall so a taken branch is never lost
                    if (redirect && aligned) begin
                        pc_out      <= redirect_target;
                        if_id_valid <= 1'b0;
                    end else if (redirect) begin
                        if_id_valid  <= 1'b0;
                        misalign_err <= 1'b1;
                        state        <= HALT;
                    end else if (stall) begin
                        state <= RUN;
                    end else if (inst_in == 32'h0) begin
                        if_id_valid <= 1'b0;
                        state       <= HALT;
                    end else begin
                        if_id_pc    <= pc_out;
                        if_id_inst  <= inst_in;
                        if_id_valid <= 1'b1;
                        pc_out      <= pc_out + 64'(PC_STEP);
                        fetch_count <= fetch_count + 32'd1;
                    end
                end
                HALT: begin
                    if_id_valid <= 1'b0;
                    if (redirect && aligned) begin
                        pc_out <= redirect_target;
                        state  <= RUN;
                    end
                end
                default: begin
                    if_id_valid <= 1'b0;
                    state       <= START;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small instruction memory model.
// Inputs change and outputs are checked on the falling clock edge.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [63:0] redirect_target;
    logic [31:0] inst_in;
    logic [63:0] pc_out;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_inst;
    logic        if_id_valid;
    logic        halted;
    logic        misalign_err;
    logic [31:0] fetch_count;

    logic [31:0] mem [64];
    int checks;
    int errors;

    fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .inst_in         (inst_in),
        .pc_out          (pc_out),
        .if_id_pc        (if_id_pc),
        .if_id_inst      (if_id_inst),
        .if_id_valid     (if_id_valid),
        .halted          (halted),
        .misalign_err    (misalign_err),
        .fetch_count     (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // addresses outside the table return a non-zero NOP
    assign inst_in = (pc_out < 64'd256) ? mem[pc_out[7:2]] : 32'h0000_0013;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_state(input string tag, input logic [63:0] pc,
                               input logic [63:0] ipc, input logic v,
                               input logic h, input logic m,
                               input logic [31:0] cnt);
        check({tag, ".pc"}, pc_out, pc);
        check({tag, ".ifpc"}, if_id_pc, ipc);
        check({tag, ".valid"}, 64'(if_id_valid), 64'(v));
        check({tag, ".halted"}, 64'(halted), 64'(h));
        check({tag, ".mis"}, 64'(misalign_err), 64'(m));
        check({tag, ".cnt"}, 64'(fetch_count), 64'(cnt));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0] = 32'h00E1_2423;
        mem[1] = 32'h0081_2703;
        mem[2] = 32'h00A9_8933;
        mem[3] = 32'h1111_1111;
        mem[4] = 32'h2222_2222;
        mem[5] = 32'h3333_3333;
        mem[6] = 32'h00C5_0533;
        mem[7] = 32'h0000_0000;

        rst = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_target = 64'h0;
        step();
        check_state("reset", 64'h0, 64'h0, 0, 0, 0, 32'd0);
        check("reset.inst", 64'(if_id_inst), 64'h0);

        rst = 1'b0;
        step();
        check_state("start", 64'h0, 64'h0, 0, 0, 0, 32'd0);

        step();
        check_state("f0", 64'h4, 64'h0, 1, 0, 0, 32'd1);
        check("f0.inst", 64'(if_id_inst), 64'h00E1_2423);
        step();
        check_state("f4", 64'h8, 64'h4, 1, 0, 0, 32'd2);
        check("f4.inst", 64'(if_id_inst), 64'h0081_2703);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_state("stall", 64'h8, 64'h4, 1, 0, 0, 32'd2);
            check("stall.inst", 64'(if_id_inst), 64'h0081_2703);
        end
        stall = 1'b0;
        step();
        check_state("f8", 64'hC, 64'h8, 1, 0, 0, 32'd3);
        check("f8.inst", 64'(if_id_inst), 64'h00A9_8933);

        stall = 1'b1;
        redirect = 1'b1;
        redirect_target = 64'h18;
        step();
        check_state("redir", 64'h18, 64'h8, 0, 0, 0, 32'd3);
        stall = 1'b0;
        redirect = 1'b0;
        step();
        check_state("f18", 64'h1C, 64'h18, 1, 0, 0, 32'd4);
        check("f18.inst", 64'(if_id_inst), 64'h00C5_0533);

        redirect = 1'b1;
        redirect_target = 64'h1A;
        step();
        check_state("misal", 64'h1C, 64'h18, 0, 1, 1, 32'd4);
        redirect = 1'b0;
        stall = 1'b1;
        step();
        check_state("halt.hold", 64'h1C, 64'h18, 0, 1, 1, 32'd4);
        check("halt.inst", 64'(if_id_inst), 64'h00C5_0533);
        stall = 1'b0;
        redirect = 1'b1;
        redirect_target = 64'h1A;
        step();
        check_state("halt.misal", 64'h1C, 64'h18, 0, 1, 1, 32'd4);
        redirect_target = 64'h0;
        step();
        check_state("halt.redir", 64'h0, 64'h18, 0, 0, 1, 32'd4);
        redirect = 1'b0;
        step();
        check_state("refetch0", 64'h4, 64'h0, 1, 0, 1, 32'd5);

        redirect = 1'b1;
        redirect_target = 64'h1C;
        step();
        check_state("to28", 64'h1C, 64'h0, 0, 0, 1, 32'd5);
        redirect = 1'b0;
        step();
        check_state("zero", 64'h1C, 64'h0, 0, 1, 1, 32'd5);
        step();
        check_state("zero.hold", 64'h1C, 64'h0, 0, 1, 1, 32'd5);

        rst = 1'b1;
        redirect = 1'b1;
        redirect_target = 64'h8;
        stall = 1'b1;
        step();
        check_state("rst2", 64'h0, 64'h0, 0, 0, 0, 32'd0);
        check("rst2.inst", 64'(if_id_inst), 64'h0);
        rst = 1'b0;
        redirect = 1'b0;
        stall = 1'b0;
        step();
        check_state("start2", 64'h0, 64'h0, 0, 0, 0, 32'd0);
        step();
        check_state("first2", 64'h4, 64'h0, 1, 0, 0, 32'd1);

        force dut.fetch_count = 32'hFFFF_FFFE;
        #1;
        release dut.fetch_count;
        step();
        check("wrap.ff", 64'(fetch_count), 64'hFFFF_FFFF);
        step();
        check("wrap.zero", 64'(fetch_count), 64'h0);
        check("wrap.pc", pc_out, 64'hC);

        redirect = 1'b1;
        redirect_target = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        check("pctop", pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
        redirect = 1'b0;
        step();
        check_state("pcwrap", 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0, 32'd1);
        check("pcwrap.inst", 64'(if_id_inst), 64'h13);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL provide parameter RESET_PC, default 64'h0, PC loaded on reset.
REQ-002 SHALL provide parameter PC_STEP, default 4, byte increment per sequential fetch.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 stall  input  1  hold PC and IF/ID register this cycle.
REQ-007 redirect  input  1  branch/jump taken; load redirect_target.
REQ-008 redirect_target  input  64  new PC on redirect.
REQ-009 inst_in  input  32  instruction word returned combinationally by instruction memory for pc_out.
REQ-010 pc_out  output  64  current PC, drives instruction memory address.
REQ-011 if_id_pc  output  64  registered PC of fetched instruction.
REQ-012 if_id_inst  output  32  registered fetched instruction.
REQ-013 if_id_valid  output  1  IF/ID register holds a live instruction.
REQ-014 halted  output  1  fetch stopped (state HALT).
REQ-015 misalign_err  output  1  sticky: redirect target not 4-byte aligned.
REQ-016 fetch_count  output  32  number of instructions delivered to IF/ID.

Function
REQ-017 SHALL implement states START, RUN, HALT; halted=1 only in HALT.
REQ-018 START: one cycle after reset, no capture, if_id_valid=0, pc_out=RESET_PC; next state RUN unconditionally.
REQ-019 RUN, per-cycle priority: redirect > stall > zero-word halt > sequential fetch.
REQ-020 RUN + redirect with redirect_target[1:0]==0: pc_out<=redirect_target, if_id_valid<=0 (flush), fetch_count unchanged, remain RUN; applies even when stall=1.
REQ-021 RUN + redirect with redirect_target[1:0]!=0: PC unchanged, if_id_valid<=0, misalign_err<=1, next state HALT.
REQ-022 RUN + stall, no redirect: pc_out, if_id_pc, if_id_inst, if_id_valid, fetch_count all hold.
REQ-023 RUN, no stall/redirect, inst_in==32'h0: treat as end of program; if_id_valid<=0, PC holds, next state HALT.
REQ-024 RUN, no stall/redirect, inst_in!=0: if_id_pc<=pc_out, if_id_inst<=inst_in, if_id_valid<=1, pc_out<=pc_out+PC_STEP, fetch_count<=fetch_count+1.
REQ-025 pc_out addition SHALL be 64-bit modulo 2^64 (wraps to 0 past 64'hFFFF_FFFF_FFFF_FFFC).
REQ-026 fetch_count SHALL wrap 32'hFFFF_FFFF -> 0 without flag.
REQ-027 HALT: PC and IF/ID contents hold, if_id_valid=0; aligned redirect -> load target, clear nothing else, next RUN; misaligned redirect stays HALT; stall ignored.
REQ-028 misalign_err SHALL stay 1 until reset once set.
REQ-029 All outputs SHALL be registered; no combinational path from inst_in to any output.

Reset
REQ-030 rst=1 at a clock edge SHALL override all other inputs and set state START, pc_out=RESET_PC, if_id_pc=0, if_id_inst=0, if_id_valid=0, halted=0, misalign_err=0, fetch_count=0.
REQ-031 Reset asserted mid-operation (any state, including during stall or redirect) SHALL take effect on that edge; first capture occurs two edges after rst deasserts.

Verification
REQ-032 Reset, memory words 0x00E12423, 0x00812703, 0x00A98933 at 0,4,8 -> after START, if_id_pc 0,4,8 on consecutive cycles, fetch_count=3, pc_out=12.
REQ-033 Stall high 3 cycles while if_id_pc=4 -> all outputs frozen 3 cycles, then if_id_pc=8 next cycle.
REQ-034 redirect=1, target=0x18, with stall=1 at pc_out=12 -> next cycle if_id_valid=0, pc_out=0x18; following cycle if_id_pc=0x18.
REQ-035 redirect target=0x1A -> misalign_err=1, halted=1, pc_out unchanged; later aligned redirect to 0 -> RUN, misalign_err stays 1.
REQ-036 inst_in=0 at pc_out=28 -> halted=1, if_id_valid=0, pc_out stays 28, fetch_count frozen; rst -> all reset values, pc_out=RESET_PC.
REQ-037 Preload fetch_count near 32'hFFFF_FFFE via long run (or forced state) -> two fetches wrap count to 0.
